multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath: steps each instruction through fetch, decode, execute, memory and write-back states and drives the shared ALU, memory port, PC and register-file control lines once per state. It supports the same instruction set as the single-cycle decoder (R-format, addi, lw, sw, andi, beq, jal) plus j. It waits on a memory-ready handshake and bounds each wait with a timeout. It sits between the instruction register's opcode field and the datapath muxes and enables.

## Interface
- TIMEOUT_CYCLES, 16: maximum consecutive cycles a memory state may wait with mem_ready=0; range 1..255.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- op_code  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA  out  1  datapath enables and selects.
- RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource  out  2  mux selects. ALUOp: 00 add, 01 sub, 10 funct, 11 and.
- state  out  4  current state code, for debug.
- mem_err  out  1  sticky memory-timeout flag.
- trap  out  1  illegal-opcode flag (see Configuration).

## Operation
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, JAL=12, TRAP=13.
- Unlisted outputs are 0 in every state.
- **FETCH**
  - Drives IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=1 only when mem_ready=1; then go to DECODE, otherwise stay.
- **DECODE**
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by op_code: 0x00→EXEC, 0x23/0x2B→MEMADR, 0x04→BRANCH, 0x02→JUMP, 0x08/0x0C→IEXEC, 0x03→JAL. Any other opcode → illegal.
- **MEMADR**: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
- **MEMRD**: IorD=1, MemRead=1. Go to MEMWB when mem_ready=1.
- **MEMWB**: RegDst=00, MemtoReg=01, RegWrite=1. Next FETCH.
- **MEMWR**: IorD=1, MemWrite=1. Go to FETCH when mem_ready=1.
- **EXEC**: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- **RWB**: RegDst=01, MemtoReg=00, RegWrite=1. Next FETCH.
- **IEXEC**: ALUSrcA=1, ALUSrcB=10, ALUOp=00 for addi, 11 for andi. Next IWB.
- **IWB**: RegDst=00, MemtoReg=00, RegWrite=1. Next FETCH.
- **BRANCH**: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next FETCH.
- **JUMP**: PCWrite=1, PCSource=10. Next FETCH.
- **JAL**: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. Next FETCH.
- **Wait timeout** (FETCH, MEMRD, MEMWR):
  - An 8-bit counter increments each cycle the FSM stays in one of these states with mem_ready=0, and clears on any state change.
  - When the counter reaches TIMEOUT_CYCLES-1 and mem_ready is still 0: set mem_err, clear the counter, go to FETCH. No IRWrite, PCWrite or RegWrite occurs for the abandoned access.
  - If mem_ready=1 arrives on that same cycle, the handshake wins: normal transition, no error.
  - mem_err stays set until reset.

## Timing
- Asynchronous reset: state=FETCH, counter=0, mem_err=0, trap=0. While rst_n=0, all control outputs are forced to 0.
- The first FETCH read is issued on the first rising edge after rst_n deasserts.
- Outputs are Moore (decoded from state), except IRWrite and PCWrite in FETCH, which are combinationally gated by mem_ready.
- Cycle counts with zero-wait memory (mem_ready=1 immediately):
  - lw: 5 cycles.
  - sw, R-format, addi, andi: 4 cycles.
  - beq, j, jal: 3 cycles.
- Each cycle of mem_ready=0 adds one cycle.
- op_code is sampled only in DECODE, MEMADR and IEXEC; changes in other states are ignored.

## Configuration
- MC_TRAP_EN defined:
  - An illegal opcode in DECODE goes to TRAP.
  - TRAP drives all controls to 0 and sets trap=1.
  - The FSM stays in TRAP until reset.
- MC_TRAP_EN undefined:
  - An illegal opcode goes straight from DECODE to FETCH and executes as a 2-cycle NOP (PC already incremented).
  - trap is tied to 0 and the TRAP state does not exist.

## Test plan
- Reset: hold rst_n=0 with mem_ready=1 → all outputs 0 and state=0. Release → IRWrite=PCWrite=1 on the first cycle, state=1 on the next.
- lw sequence: op_code=0x23, mem_ready=1 → states 0,1,2,3,4,0. MemtoReg=01 and RegWrite=1 only in state 4.
- Wait states: sw with mem_ready held 0 for 3 cycles in MEMWR → MemWrite=1 for 4 cycles, then FETCH, mem_err=0.
- Timeout: TIMEOUT_CYCLES=4, mem_ready=0 in FETCH → after 4 cycles mem_err=1, state=0, no IRWrite pulse. Asserting mem_ready on the 4th cycle instead → normal DECODE, mem_err=0.
- Control mix: beq → PCWriteCond=1, ALUOp=01 for 1 cycle. jal → RegDst=10, MemtoReg=10, PCWrite=1. andi → ALUOp=11 in IEXEC.
- Illegal opcode 0x3F: with MC_TRAP_EN → state=13, trap=1 until reset. Without it → back to FETCH after DECODE, no RegWrite or MemWrite pulse.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control sequencer with memory-wait timeout
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   op_code[5:0]      IR[31:26], sampled in DECODE, MEMADR and IEXEC only
//   mem_ready         memory finished the current read/write this cycle
//   PCWrite .. ALUSrcA  1-bit datapath enables/selects
//   RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource  2-bit mux selects
//   state[3:0]        current state code (debug)
//   mem_err           sticky memory-timeout flag
//   trap              illegal-opcode flag
// Build option: define MC_TRAP_EN to trap illegal opcodes in a terminal TRAP
// state; otherwise they retire as a 2-cycle NOP.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       mem_err,
    output logic       trap
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
`ifdef MC_TRAP_EN
        S_JAL    = 4'd12,
        S_TRAP   = 4'd13
`else
        S_JAL    = 4'd12
`endif
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     cur_state, nxt_state;
    ctrl_t      ctl;
    logic [7:0] wait_cnt;
    logic       err_q;
    logic       in_wait;
    logic       timeout;

    assign in_wait = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
    // A late mem_ready on the final allowed cycle still wins over the timeout.
    assign timeout = in_wait && !mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            wait_cnt  <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (timeout) begin
                err_q    <= 1'b1;
                wait_cnt <= 8'd0;
            end else if (in_wait && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        ctl       = '0;
        case (cur_state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
                if (mem_ready)    nxt_state = S_DECODE;
                else if (timeout) nxt_state = S_FETCH;
            end
            S_DECODE: begin
                ctl.alu_src_b = 2'b11;
                case (op_code)
                    6'h00:        nxt_state = S_EXEC;
                    6'h23, 6'h2B: nxt_state = S_MEMADR;
                    6'h04:        nxt_state = S_BRANCH;
                    6'h02:        nxt_state = S_JUMP;
                    6'h08, 6'h0C: nxt_state = S_IEXEC;
                    6'h03:        nxt_state = S_JAL;
`ifdef MC_TRAP_EN
                    default:      nxt_state = S_TRAP;
`else
                    default:      nxt_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                nxt_state = (op_code == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctl.i_or_d   = 1'b1;
                ctl.mem_read = 1'b1;
                if (mem_ready)    nxt_state = S_MEMWB;
                else if (timeout) nxt_state = S_FETCH;
            end
            S_MEMWB: begin
                ctl.mem_to_reg = 2'b01;
                ctl.reg_write  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_MEMWR: begin
                ctl.i_or_d    = 1'b1;
                ctl.mem_write = 1'b1;
                if (mem_ready || timeout) nxt_state = S_FETCH;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b10;
                nxt_state = S_RWB;
            end
            S_RWB: begin
                ctl.reg_dst   = 2'b01;
                ctl.reg_write = 1'b1;
                nxt_state = S_FETCH;
            end
            S_IEXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_op    = (op_code == 6'h0C) ? 2'b11 : 2'b00;
                nxt_state = S_IWB;
            end
            S_IWB: begin
                ctl.reg_write = 1'b1;
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = 2'b01;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = 2'b01;
                nxt_state = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = 2'b10;
                nxt_state = S_FETCH;
            end
            S_JAL: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = 2'b10;
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 2'b10;
                ctl.mem_to_reg = 2'b10;
                nxt_state = S_FETCH;
            end
`ifdef MC_TRAP_EN
            S_TRAP: nxt_state = S_TRAP;
`endif
            default: nxt_state = S_FETCH;
        endcase
    end

    // Controls are held low for the whole time reset is asserted.
    assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
            RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource} = rst_n ? ctl : '0;

    assign state   = cur_state;
    assign mem_err = err_q;
`ifdef MC_TRAP_EN
    assign trap = (cur_state == S_TRAP);
`else
    assign trap = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl (default build)
module tb_multicycle_ctrl;
    localparam int T = 4;
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_EXEC = 6, S_RWB = 7, S_BRANCH = 8, S_JUMP = 9,
                   S_IEXEC = 10, S_IWB = 11, S_JAL = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op_code;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       mem_err, trap;

    multicycle_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .mem_err(mem_err), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, rgw, asa;
        logic [1:0] rdst, m2r, asb, aop, pcs;
    } ctrl_t;

    typedef struct {
        int    st;
        ctrl_t c;
        bit    err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   model_err = 1'b0;

    function automatic ctrl_t got_ctrl();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource};
    endfunction

    // Control lines the datasheet lists for each step of an instruction.
    function automatic ctrl_t spec_ctrl(int st, bit rdy, logic [5:0] op);
        ctrl_t c = '0;
        case (st)
            S_FETCH:  begin c.mrd = 1; c.asb = 2'b01; c.irw = rdy; c.pcw = rdy; end
            S_DECODE: c.asb = 2'b11;
            S_MEMADR: begin c.asa = 1; c.asb = 2'b10; end
            S_MEMRD:  begin c.iord = 1; c.mrd = 1; end
            S_MEMWB:  begin c.m2r = 2'b01; c.rgw = 1; end
            S_MEMWR:  begin c.iord = 1; c.mwr = 1; end
            S_EXEC:   begin c.asa = 1; c.aop = 2'b10; end
            S_RWB:    begin c.rdst = 2'b01; c.rgw = 1; end
            S_IEXEC:  begin c.asa = 1; c.asb = 2'b10; c.aop = (op == 6'h0C) ? 2'b11 : 2'b00; end
            S_IWB:    c.rgw = 1;
            S_BRANCH: begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; end
            S_JUMP:   begin c.pcw = 1; c.pcs = 2'b10; end
            S_JAL:    begin c.pcw = 1; c.pcs = 2'b10; c.rgw = 1; c.rdst = 2'b10; c.m2r = 2'b10; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    // One clock of stimulus plus the response the model expects during it.
    task automatic emit(int st, bit rdy, logic [5:0] op);
        exp_t e;
        mem_ready = rdy;
        op_code   = op;
        e.st  = st;
        e.c   = spec_ctrl(st, rdy, op);
        e.err = model_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // A memory step that waits w cycles; T or more waits means the access is abandoned.
    task automatic mem_phase(int st, int w, output bit ok);
        if (w >= T) begin
            for (int i = 0; i < T; i++) emit(st, 1'b0, rnd_op());
            model_err = 1'b1;
            ok = 1'b0;
        end else begin
            for (int i = 0; i < w; i++) emit(st, 1'b0, rnd_op());
            emit(st, 1'b1, rnd_op());
            ok = 1'b1;
        end
    endtask

    task automatic run_instr(logic [5:0] op, int wf, int wm);
        bit ok;
        mem_phase(S_FETCH, wf, ok);
        if (!ok) return;
        emit(S_DECODE, 1'($urandom), op);
        case (op)
            6'h00: begin emit(S_EXEC, 1'($urandom), rnd_op()); emit(S_RWB, 1'($urandom), rnd_op()); end
            6'h23: begin
                emit(S_MEMADR, 1'($urandom), op);
                mem_phase(S_MEMRD, wm, ok);
                if (ok) emit(S_MEMWB, 1'($urandom), rnd_op());
            end
            6'h2B: begin emit(S_MEMADR, 1'($urandom), op); mem_phase(S_MEMWR, wm, ok); end
            6'h04: emit(S_BRANCH, 1'($urandom), rnd_op());
            6'h02: emit(S_JUMP, 1'($urandom), rnd_op());
            6'h03: emit(S_JAL, 1'($urandom), rnd_op());
            6'h08, 6'h0C: begin emit(S_IEXEC, 1'($urandom), op); emit(S_IWB, 1'($urandom), rnd_op()); end
            default: ;
        endcase
    endtask

    // Monitor: one scoreboard entry per clock, checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (state !== 4'(e.st) || got_ctrl() !== e.c || mem_err !== e.err || trap !== 1'b0) begin
                    bad++;
                    $display("FAIL cycle @%0t: got state=%0d ctrl=%h mem_err=%b trap=%b, want state=%0d ctrl=%h mem_err=%b trap=0",
                             $time, state, got_ctrl(), mem_err, trap, e.st, e.c, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h3F};

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; op_code = 6'h23;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (got_ctrl() !== '0 || state !== 4'd0 || mem_err !== 1'b0 || trap !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got ctrl=%h state=%0d mem_err=%b trap=%b, want all 0",
                     got_ctrl(), state, mem_err, trap);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_instr(6'h23, 0, 0);     // lw, zero-wait: 0,1,2,3,4
        run_instr(6'h2B, 0, 3);     // sw, MEMWR held 4 cycles
        run_instr(6'h04, 0, 0);     // beq
        run_instr(6'h03, 0, 0);     // jal
        run_instr(6'h0C, 0, 0);     // andi
        run_instr(6'h08, 1, 0);     // addi
        run_instr(6'h00, 0, 0);     // R-format
        run_instr(6'h02, 2, 0);     // j
        run_instr(6'h3F, 0, 0);     // illegal -> NOP
        run_instr(6'h23, T - 1, T - 1);  // ready on the last allowed cycle wins
        run_instr(6'h00, T, 0);     // fetch timeout
        run_instr(6'h23, 0, T);     // read timeout, no write-back
        run_instr(6'h2B, 0, T + 1); // write timeout

        for (int n = 0; n < 200; n++) begin
            int wf, wm;
            wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T + 1)) : 0;
            wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, T + 1)) : 0;
            run_instr(ops[$urandom_range(0, 8)], wf, wm);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end

        // Asynchronous reset asserted mid-cycle.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (got_ctrl() !== '0 || state !== 4'd0 || mem_err !== 1'b0 || trap !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got ctrl=%h state=%0d mem_err=%b trap=%b, want all 0",
                     got_ctrl(), state, mem_err, trap);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
